sr_ff_bank: RTL and testbench

//   Parametrised bank of WIDTH independent clocked SR flip-flops sharing one clock/reset.

---
 rtl/sr_ff_bank.sv | 78 +++++++
 tb/tb_sr_ff_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent clocked SR flip-flops with selectable S=R=1 resolution,
// change strobes and invalid-input error flag, sticky flag and saturating count.
module sr_ff_bank #(
  parameter int               WIDTH        = 8,
  parameter int               INVALID_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL     = '0,
  parameter int               ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     s,
  input  logic [WIDTH-1:0]     r,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [WIDTH-1:0] q_next;
  logic             err_cond;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic inv_val;
      // Resolution of the colliding s=r=1 case is fixed at elaboration time.
      assign inv_val = (INVALID_MODE == 1) ? 1'b1 :
                       (INVALID_MODE == 2) ? 1'b0 :
                       (INVALID_MODE == 3) ? ~q[gi] : q[gi];
      assign q_next[gi] = (s[gi] && r[gi]) ? inv_val :
                          s[gi]            ? 1'b1    :
                          r[gi]            ? 1'b0    : q[gi];
    end
  endgenerate

  assign err_cond = en & ~clr & (|(s & r));
  assign qn       = ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= INIT_VAL;
      rise       <= '0;
      fall       <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr) begin
      // Strobes still report the edge caused by the clear itself.
      q          <= INIT_VAL;
      rise       <= ~q & INIT_VAL;
      fall       <= q & ~INIT_VAL;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (!en) begin
      rise <= '0;
      fall <= '0;
      err  <= 1'b0;
    end else begin
      q          <= q_next;
      rise       <= ~q & q_next;
      fall       <= q & ~q_next;
      err        <= err_cond;
      err_sticky <= err_sticky | err_cond;
      if (err_cond && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench for sr_ff_bank: four instances (one per INVALID_MODE, incl. WIDTH=1)
// share stimulus; a reference model pushes expectations that a monitor pops and compares.
module tb_sr_ff_bank;

  localparam int         W    [4] = '{8, 1, 8, 8};
  localparam logic [7:0] INIT [4] = '{8'h00, 8'h01, 8'hA5, 8'h00};
  localparam int         CMAX [4] = '{255, 3, 7, 255};

  typedef struct packed {
    logic [3:0][7:0] q;
    logic [3:0][7:0] rise;
    logic [3:0][7:0] fall;
    logic [3:0][7:0] cnt;
    logic [3:0]      err;
    logic [3:0]      sticky;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, clr;
  logic [7:0] s, r;

  logic [7:0] q0, qn0, rise0, fall0, cnt0, cnt3;
  logic [0:0] q1, qn1, rise1, fall1;
  logic [1:0] cnt1;
  logic [7:0] q2, qn2, rise2, fall2, q3, qn3, rise3, fall3;
  logic [2:0] cnt2;
  logic [3:0] err_v, sticky_v;

  logic [7:0] q_a[4], qn_a[4], rise_a[4], fall_a[4], cnt_a[4];

  exp_t       sb[$];
  logic [7:0] mq[4], mcnt[4];
  logic       msticky[4];
  int         n_pass = 0, n_tot = 0;
  event       mon_ev;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(8), .INVALID_MODE(0), .INIT_VAL(8'h00), .ERR_CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .q(q0), .qn(qn0),
    .rise(rise0), .fall(fall0), .err(err_v[0]), .err_sticky(sticky_v[0]), .err_cnt(cnt0));
  sr_ff_bank #(.WIDTH(1), .INVALID_MODE(1), .INIT_VAL(1'b1), .ERR_CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s[0:0]), .r(r[0:0]), .q(q1), .qn(qn1),
    .rise(rise1), .fall(fall1), .err(err_v[1]), .err_sticky(sticky_v[1]), .err_cnt(cnt1));
  sr_ff_bank #(.WIDTH(8), .INVALID_MODE(2), .INIT_VAL(8'hA5), .ERR_CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .q(q2), .qn(qn2),
    .rise(rise2), .fall(fall2), .err(err_v[2]), .err_sticky(sticky_v[2]), .err_cnt(cnt2));
  sr_ff_bank #(.WIDTH(8), .INVALID_MODE(3), .INIT_VAL(8'h00), .ERR_CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .q(q3), .qn(qn3),
    .rise(rise3), .fall(fall3), .err(err_v[3]), .err_sticky(sticky_v[3]), .err_cnt(cnt3));

  assign q_a[0] = q0;  assign q_a[1] = {7'b0, q1};  assign q_a[2] = q2;  assign q_a[3] = q3;
  assign qn_a[0] = qn0; assign qn_a[1] = {7'b0, qn1}; assign qn_a[2] = qn2; assign qn_a[3] = qn3;
  assign rise_a[0] = rise0; assign rise_a[1] = {7'b0, rise1};
  assign rise_a[2] = rise2; assign rise_a[3] = rise3;
  assign fall_a[0] = fall0; assign fall_a[1] = {7'b0, fall1};
  assign fall_a[2] = fall2; assign fall_a[3] = fall3;
  assign cnt_a[0] = cnt0; assign cnt_a[1] = {6'b0, cnt1};
  assign cnt_a[2] = {5'b0, cnt2}; assign cnt_a[3] = cnt3;

  function automatic logic [7:0] mask_of(input int d);
    return (W[d] == 8) ? 8'hFF : 8'h01;
  endfunction

  task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] expv);
    n_tot++;
    if (act !== expv)
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, expv, $time);
    else
      n_pass++;
  endtask

  // Reference model: apply the SR truth table channel by channel.
  task automatic model_step(input logic e, input logic c, input logic [7:0] sv, input logic [7:0] rv);
    exp_t ex;
    for (int d = 0; d < 4; d++) begin
      logic [7:0] m, sm, rm, old, nq;
      logic ec;
      m = mask_of(d); sm = sv & m; rm = rv & m; old = mq[d]; nq = old;
      if (c) nq = INIT[d];
      else if (e) begin
        for (int i = 0; i < W[d]; i++) begin
          if (sm[i] && rm[i]) begin
            case (d)
              1: nq[i] = 1'b1;
              2: nq[i] = 1'b0;
              3: nq[i] = ~old[i];
              default: nq[i] = old[i];
            endcase
          end else if (sm[i]) nq[i] = 1'b1;
          else if (rm[i]) nq[i] = 1'b0;
        end
      end
      ec = e && !c && ((sm & rm) != 8'h00);
      if (c) begin
        mcnt[d] = 8'h00; msticky[d] = 1'b0;
      end else begin
        msticky[d] = msticky[d] | ec;
        if (ec && (int'(mcnt[d]) < CMAX[d])) mcnt[d] = mcnt[d] + 8'd1;
      end
      ex.q[d] = nq; ex.rise[d] = ~old & nq & m; ex.fall[d] = old & ~nq & m;
      ex.err[d] = ec; ex.sticky[d] = msticky[d]; ex.cnt[d] = mcnt[d];
      mq[d] = nq;
    end
    sb.push_back(ex);
  endtask

  task automatic model_reset(input logic push);
    exp_t ex;
    for (int d = 0; d < 4; d++) begin
      mq[d] = INIT[d]; mcnt[d] = 8'h00; msticky[d] = 1'b0;
      ex.q[d] = INIT[d]; ex.rise[d] = 8'h00; ex.fall[d] = 8'h00; ex.cnt[d] = 8'h00;
      ex.err[d] = 1'b0; ex.sticky[d] = 1'b0;
    end
    if (push) sb.push_back(ex);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic e, input logic c, input logic [7:0] sv, input logic [7:0] rv);
    en = e; clr = c; s = sv; r = rv;
    model_step(e, c, sv, rv);
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge arrives.
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset(1'b1);
    #1 -> mon_ev;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    -> mon_ev;
  end

  initial begin : monitor
    exp_t ex;
    forever begin
      @(mon_ev);
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        for (int d = 0; d < 4; d++) begin
          chk("q", d, q_a[d], ex.q[d]);
          chk("qn", d, qn_a[d], ~ex.q[d] & mask_of(d));
          chk("rise", d, rise_a[d], ex.rise[d]);
          chk("fall", d, fall_a[d], ex.fall[d]);
          chk("err", d, {7'b0, err_v[d]}, {7'b0, ex.err[d]});
          chk("err_sticky", d, {7'b0, sticky_v[d]}, {7'b0, ex.sticky[d]});
          chk("err_cnt", d, cnt_a[d], ex.cnt[d]);
        end
        $display("txn t=%0t q=%h/%h/%h/%h err=%b cnt=%h/%h/%h/%h", $time,
                 q_a[0], q_a[1], q_a[2], q_a[3], err_v, cnt_a[0], cnt_a[1], cnt_a[2], cnt_a[3]);
      end
    end
  end

  // qn must mirror q at all times, reset included.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      n_tot++;
      assert ((qn_a[d] ^ q_a[d]) == mask_of(d)) n_pass++;
      else $display("FAIL qn_inv dut%0d: got q=%h qn=%h required qn=%h", d, q_a[d], qn_a[d],
                    ~q_a[d] & mask_of(d));
    end
  end

  initial begin : stimulus
    rst = 1'b1; en = 1'b0; clr = 1'b0; s = 8'h00; r = 8'h00;
    model_reset(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step(1'b1, 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'hFF, 8'h00);
    async_reset();
    step(1'b1, 1'b0, 8'h05, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h01);
    step(1'b1, 1'b0, 8'h0F, 8'hF0);
    repeat (5) step(1'b1, 1'b0, 8'hFF, 8'hFF);
    repeat (5) step(1'b0, 1'b0, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, 8'h81, 8'h7E);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, 8'h3C, 8'h00);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                8'($urandom), 8'($urandom & $urandom));
    end

    repeat (2) @(negedge clk);
    n_tot++;
    if (sb.size() != 0)
      $display("FAIL drain: got %0d pending expectations required 0", sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
